// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock,
// retries on timeout, latches a fault, and gates the downstream system reset.
module pll_lock_ctrl #(
   parameter int RST_HOLD_CYC    = 16,
   parameter int LOCK_TIMEOUT    = 50000,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int MAX_RETRY       = 3,
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic               clkin1,
   input  logic               rst_n,
   input  logic               pll_lock,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [7:0]         loss_cnt
);

   localparam int CNT_MAX0 = (RST_HOLD_CYC > LOCK_TIMEOUT) ? RST_HOLD_CYC : LOCK_TIMEOUT;
   localparam int CNT_MAX  = (CNT_MAX0 > LOCK_STABLE_CYC) ? CNT_MAX0 : LOCK_STABLE_CYC;
   localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_RST_HOLD,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAULT
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [RETRY_W-1:0] retry_reg, retry_next;
   logic [7:0]         loss_reg, loss_next;
   logic [1:0]         sync_reg;
   logic               lock_s;
   logic               pll_rst_reg, sys_rst_n_reg, ready_reg, fault_reg;

   assign lock_s = sync_reg[1];

   always_ff @(posedge clkin1) begin
      if (!rst_n) begin
         state_reg     <= ST_RST_HOLD;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         loss_reg      <= '0;
         sync_reg      <= '0;
         pll_rst_reg   <= 1'b1;
         sys_rst_n_reg <= 1'b0;
         ready_reg     <= 1'b0;
         fault_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         loss_reg      <= loss_next;
         sync_reg      <= {sync_reg[0], pll_lock};
         // Outputs decode the next state so they line up with the state register.
         pll_rst_reg   <= (state_next == ST_RST_HOLD) || (state_next == ST_FAULT);
         sys_rst_n_reg <= (state_next == ST_RUN);
         ready_reg     <= (state_next == ST_RUN);
         fault_reg     <= (state_next == ST_FAULT);
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      retry_next = retry_reg;
      loss_next  = loss_reg;
      if (relock_req) begin
         state_next = ST_RST_HOLD;
         cnt_next   = '0;
         retry_next = '0;
      end else begin
         case (state_reg)
            ST_RST_HOLD: begin
               if (cnt_reg == HOLD_LAST) begin
                  state_next = ST_WAIT_LOCK;
                  cnt_next   = '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_next = ST_STABLE;
                  cnt_next   = '0;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  cnt_next = '0;
                  if (retry_reg == RETRY_LAST) begin
                     state_next = ST_FAULT;
                  end else begin
                     state_next = ST_RST_HOLD;
                     retry_next = retry_reg + 1'b1;
                  end
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_next = ST_WAIT_LOCK;
                  cnt_next   = '0;
               end else if (cnt_reg == STABLE_LAST) begin
                  state_next = ST_RUN;
                  cnt_next   = '0;
                  retry_next = '0;
               end
            end
            ST_RUN: begin
               cnt_next = '0;
               if (!lock_s) begin
                  state_next = ST_RST_HOLD;
                  if (loss_reg != 8'hFF) begin
                     loss_next = loss_reg + 1'b1;
                  end
               end
            end
            ST_FAULT: begin
               cnt_next = '0;
            end
            default: begin
               state_next = ST_RST_HOLD;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign pll_rst   = pll_rst_reg;
   assign sys_rst_n = sys_rst_n_reg;
   assign ready     = ready_reg;
   assign fault     = fault_reg;
   assign retry_cnt = retry_reg;
   assign loss_cnt  = loss_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: stimulus queues expected output-vector changes
// with their hold durations; a monitor compares every observed change against the queue.
module tb_pll_lock_ctrl;

   logic       clkin1 = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   pll_lock_ctrl #(
      .RST_HOLD_CYC   (4),
      .LOCK_TIMEOUT   (32),
      .LOCK_STABLE_CYC(8),
      .MAX_RETRY      (2)
   ) dut (
      .clkin1    (clkin1),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .relock_req(relock_req),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .fault     (fault),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   always #10 clkin1 = ~clkin1;

   typedef struct {
      int          dur;
      logic [13:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always @(posedge clkin1) cyc <= cyc + 1;

   function automatic logic [13:0] ov(input bit pr, input bit sr, input bit rd, input bit ft,
                                      input logic [1:0] rc, input logic [7:0] lc);
      return {pr, sr, rd, ft, rc, lc};
   endfunction

   task automatic push(input int d, input logic [13:0] v);
      exp_t e;
      e.dur = d;
      e.vec = v;
      exp_q.push_back(e);
   endtask

   task automatic at(input int n);
      while (cyc < n) @(negedge clkin1);
   endtask

   // Monitor: an output change is the "transaction"; dur is how long the previous vector held.
   logic [13:0] prev_vec;
   int          run_len = 0;
   bit          started = 1'b0;

   always @(negedge clkin1) begin
      logic [13:0] cur;
      exp_t        e;
      if (cyc >= 1) begin
         cur = {pll_rst, sys_rst_n, ready, fault, retry_cnt, loss_cnt};
         if (!started || cur !== prev_vec) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               total_cnt++;
               if (cur === e.vec) pass_cnt++;
               else $display("FAIL value cyc=%0d got=%h required=%h", cyc, cur, e.vec);
               if (e.dur >= 0) begin
                  total_cnt++;
                  if (run_len == e.dur) pass_cnt++;
                  else $display("FAIL hold_time cyc=%0d got=%0d required=%0d", cyc, run_len, e.dur);
               end
               $display("cyc=%0d vec=%h held=%0d", cyc, cur, run_len);
            end
            prev_vec = cur;
            run_len  = 1;
            started  = 1'b1;
         end else begin
            run_len++;
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      pll_lock   = 1'b0;
      relock_req = 1'b0;

      // Reset, 4-cycle PLL reset pulse, lock at cycle 10, RUN after 8 stable cycles.
      push(-1, ov(1, 0, 0, 0, 2'd0, 8'd0));
      push(6,  ov(0, 0, 0, 0, 2'd0, 8'd0));
      push(13, ov(0, 1, 1, 0, 2'd0, 8'd0));
      at(3);  rst_n = 1'b1;
      at(9);  pll_lock = 1'b1;

      // One-cycle lock drop in RUN.
      push(7,  ov(1, 0, 0, 0, 2'd0, 8'd1));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd1));
      push(9,  ov(0, 1, 1, 0, 2'd0, 8'd1));
      at(24); pll_lock = 1'b0;
      at(25); pll_lock = 1'b1;

      // Relock from RUN, then a lock glitch at STABLE cnt=5 delays RUN.
      push(5,  ov(1, 0, 0, 0, 2'd0, 8'd1));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd1));
      push(16, ov(0, 1, 1, 0, 2'd0, 8'd1));
      at(44); relock_req = 1'b1;
      at(45); relock_req = 1'b0;
      at(53); pll_lock = 1'b0;
      at(54); pll_lock = 1'b1;

      // Lock lost for good: three rounds then FAULT; relock_req clears it.
      push(7,  ov(1, 0, 0, 0, 2'd0, 8'd2));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd2));
      push(32, ov(1, 0, 0, 0, 2'd1, 8'd2));
      push(4,  ov(0, 0, 0, 0, 2'd1, 8'd2));
      push(32, ov(1, 0, 0, 0, 2'd2, 8'd2));
      push(4,  ov(0, 0, 0, 0, 2'd2, 8'd2));
      push(32, ov(1, 0, 0, 1, 2'd2, 8'd2));
      push(6,  ov(1, 0, 0, 0, 2'd0, 8'd2));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd2));
      at(69);  pll_lock = 1'b0;
      at(185); relock_req = 1'b1;
      at(186); relock_req = 1'b0;

      // relock_req coinciding with a timeout wins; retry_cnt stays 0.
      push(32, ov(1, 0, 0, 0, 2'd0, 8'd2));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd2));
      at(221); relock_req = 1'b1;
      at(222); relock_req = 1'b0;

      // Reach RUN, then rst_n in RUN restores reset values including loss_cnt.
      push(14, ov(0, 1, 1, 0, 2'd0, 8'd2));
      push(5,  ov(1, 0, 0, 0, 2'd0, 8'd0));
      push(4,  ov(0, 0, 0, 0, 2'd0, 8'd0));
      push(9,  ov(0, 1, 1, 0, 2'd0, 8'd0));
      at(229); pll_lock = 1'b1;
      at(244); rst_n = 1'b0;
      at(245); rst_n = 1'b1;

      at(265);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total_cnt++;
         $display("FAIL missing_change got=none required=%h", e.vec);
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
